// File: rtl/rv32i_mc_pkg.sv
// rv32i_mc_pkg: shared opcodes, funct3 codes, FSM states, line geometry and ALU helper for rv32i_mc_core
package rv32i_mc_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h1ECEB000;
  localparam logic [31:0] HALT_INSN_DEF = 32'hF0002013;
  localparam int LINE_BITS = 256;
  localparam int BEATS = 4;
  localparam int BEAT_BITS = LINE_BITS / BEATS;
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_OP     = 7'b0110011
  } opcode_e;
  localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4, F3_SR = 3'd5, F3_OR = 3'd6, F3_AND = 3'd7;
  localparam logic [2:0] F3_LB = 3'd0, F3_LH = 3'd1, F3_LW = 3'd2, F3_LBU = 3'd4, F3_LHU = 3'd5;
  typedef enum logic [2:0] {FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, STORE_WR, COMMIT} state_e;
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      F3_ADD:  alu = alt ? a - b : a + b;
      F3_SLL:  alu = a << b[4:0];
      F3_SLT:  alu = {31'b0, $signed(a) < $signed(b)};
      F3_SLTU: alu = {31'b0, a < b};
      F3_XOR:  alu = a ^ b;
      F3_SR:   alu = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      F3_OR:   alu = a | b;
      default: alu = a & b;
    endcase
  endfunction
endpackage

// File: rtl/rv32i_mc_regfile.sv
// rv32i_mc_regfile: 32x32 register file, ports clk/rst, read ra1->rd1 and ra2->rd2 (combinational), write we/wa/wd (sync), x0 never written
module rv32i_mc_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] r [32];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < 32; i++) r[i] <= '0;
    else if (we && wa != 5'd0) r[wa] <= wd;
  assign rd1 = r[ra1];
  assign rd2 = r[ra2];
endmodule

// File: rtl/rv32i_mc_core.sv
// rv32i_mc_core: multicycle RV32I over a 4-beat 64-bit bmem line port (clk, rst, bmem_* req/resp) with internal commit_* and halt_o probes; LINE_REUSE_EN keeps the last fetched line
import rv32i_mc_pkg::*;
module rv32i_mc_core #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] HALT_INSN = HALT_INSN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  output logic        bmem_write,
  output logic [63:0] bmem_wdata,
  input  logic        bmem_ready,
  input  logic [31:0] bmem_raddr,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
);
  state_e state, nxt;
  opcode_e op;
  logic [31:0] pc, insn_q, wd_q, npc_q, ea_q, ins, rs1v, rs2v, i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [31:0] wd, npc, ea, ea_al, old_word, sdata, bmask, ld_sh, ldata, fetch_line, mem_line;
  logic [63:0] order;
  logic [255:0] line, mline, hit_line;
  logic [2:0] f3;
  logic [1:0] cnt;
  logic [3:0] m4;
  logic [4:0] sh, rd_a;
  logic wact, halt_o, hit, acc, is_ld, is_st, wr_rd, take, alt;
  logic commit_valid;
  logic [63:0] commit_order;
  logic [31:0] commit_insn, commit_pc_rdata, commit_pc_wdata, commit_rs1_rdata, commit_rs2_rdata, commit_rd_wdata;
  logic [31:0] commit_mem_addr, commit_mem_rdata, commit_mem_wdata;
  logic [4:0] commit_rs1_addr, commit_rs2_addr, commit_rd_addr;
  logic [3:0] commit_mem_rmask, commit_mem_wmask;
  assign ins = state == EXEC ? line[32*pc[4:2] +: 32] : insn_q;
  assign op = opcode_e'(ins[6:0]);
  assign f3 = ins[14:12];
  assign i_imm = {{20{ins[31]}}, ins[31:20]};
  assign s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign u_imm = {ins[31:12], 12'b0};
  assign j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  rv32i_mc_regfile u_rf (
    .clk(clk), .rst(rst), .ra1(ins[19:15]), .ra2(ins[24:20]), .wa(rd_a),
    .we(commit_valid), .wd(commit_rd_wdata), .rd1(rs1v), .rd2(rs2v)
  );
  assign is_ld = op == OP_LOAD;
  assign is_st = op == OP_STORE;
  assign wr_rd = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP};
  assign rd_a = wr_rd ? ins[11:7] : 5'd0;
  assign take = f3[2:1] == 2'b00 ? (rs1v == rs2v) ^ f3[0] :
                f3[2:1] == 2'b10 ? ($signed(rs1v) < $signed(rs2v)) ^ f3[0] :
                f3[2:1] == 2'b11 ? (rs1v < rs2v) ^ f3[0] : 1'b0;
  assign alt = op == OP_OP ? ins[30] : f3 == F3_SR && ins[30];
  assign wd = op == OP_LUI ? u_imm :
              op == OP_AUIPC ? pc + u_imm :
              op == OP_JAL || op == OP_JALR ? pc + 32'd4 :
              op == OP_IMM || op == OP_OP ? alu(f3, alt, rs1v, op == OP_OP ? rs2v : i_imm) : 32'd0;
  assign npc = op == OP_JAL ? pc + j_imm :
               op == OP_JALR ? (rs1v + i_imm) & ~32'd1 :
               op == OP_BRANCH && take ? pc + b_imm : pc + 32'd4;
  assign ea = rs1v + (is_st ? s_imm : i_imm);
  assign ea_al = f3[1:0] == 2'b01 ? {ea[31:1], 1'b0} : f3[1:0] == 2'b10 ? {ea[31:2], 2'b0} : ea;
  assign sh = {ea_q[1:0], 3'b0};
  assign m4 = f3[1:0] == 2'b00 ? 4'b0001 << ea_q[1:0] : f3[1:0] == 2'b01 ? 4'b0011 << ea_q[1:0] : 4'hF;
  assign bmask = {{8{m4[3]}}, {8{m4[2]}}, {8{m4[1]}}, {8{m4[0]}}};
  assign old_word = line[32*ea_q[4:2] +: 32];
  assign sdata = (rs2v << sh) & bmask;
  assign ld_sh = old_word >> sh;
  assign ldata = f3 == F3_LB ? {{24{ld_sh[7]}}, ld_sh[7:0]} :
                 f3 == F3_LH ? {{16{ld_sh[15]}}, ld_sh[15:0]} :
                 f3 == F3_LBU ? {24'b0, ld_sh[7:0]} :
                 f3 == F3_LHU ? {16'b0, ld_sh[15:0]} : ld_sh;
  always_comb begin
    mline = line;
    mline[32*ea_q[4:2] +: 32] = (old_word & ~bmask) | sdata;
  end
  assign fetch_line = {pc[31:5], 5'b0};
  assign mem_line = {ea_q[31:5], 5'b0};
  assign acc = (state == FETCH_WAIT || state == MEM_WAIT) && bmem_rvalid &&
               bmem_raddr == (state == FETCH_WAIT ? fetch_line : mem_line);
  assign bmem_read = !rst && !halt_o && bmem_ready && ((state == FETCH_REQ && !hit) || state == MEM_REQ);
  assign bmem_write = !rst && state == STORE_WR && (wact || bmem_ready);
  assign bmem_addr = bmem_read && state == FETCH_REQ ? fetch_line : bmem_read || bmem_write ? mem_line : '0;
  assign bmem_wdata = bmem_write ? mline[64*cnt +: 64] : '0;
`ifdef LINE_REUSE_EN
  logic ic_v;
  logic [26:0] ic_tag;
  logic [255:0] ic_line;
  assign hit = ic_v && ic_tag == pc[31:5] && !halt_o && state == FETCH_REQ;
  assign hit_line = ic_line;
  always_ff @(posedge clk)
    if (rst) begin
      ic_v <= 1'b0;
      ic_tag <= '0;
      ic_line <= '0;
    end else if (acc && cnt == 2'd3 && state == FETCH_WAIT) begin
      ic_v <= 1'b1;
      ic_tag <= pc[31:5];
      ic_line <= {bmem_rdata, line[191:0]};
    end else if (bmem_write && cnt == 2'd3 && ic_v && ic_tag == ea_q[31:5]) ic_line <= mline;
`else
  assign hit = 1'b0;
  assign hit_line = '0;
`endif
  always_ff @(posedge clk) state <= rst ? FETCH_REQ : nxt;
  always_comb begin
    nxt = state;
    case (state)
      FETCH_REQ:  nxt = hit ? EXEC : bmem_read ? FETCH_WAIT : FETCH_REQ;
      FETCH_WAIT: nxt = acc && cnt == 2'd3 ? EXEC : FETCH_WAIT;
      EXEC:       nxt = is_ld || is_st ? MEM_REQ : COMMIT;
      MEM_REQ:    nxt = bmem_read ? MEM_WAIT : MEM_REQ;
      MEM_WAIT:   nxt = acc && cnt == 2'd3 ? (is_st ? STORE_WR : COMMIT) : MEM_WAIT;
      STORE_WR:   nxt = bmem_write && cnt == 2'd3 ? COMMIT : STORE_WR;
      default:    nxt = FETCH_REQ;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      pc <= RESET_PC;
      order <= '0;
      cnt <= '0;
      wact <= 1'b0;
      halt_o <= 1'b0;
      insn_q <= '0;
      wd_q <= '0;
      npc_q <= '0;
      ea_q <= '0;
      line <= '0;
    end else begin
      if (hit) line <= hit_line;
      if (acc) line[64*cnt +: 64] <= bmem_rdata;
      if (acc || bmem_write) cnt <= cnt + 2'd1;
      if (bmem_write) wact <= cnt != 2'd3;
      if (state == EXEC) begin
        insn_q <= ins;
        wd_q <= wd;
        npc_q <= npc;
        ea_q <= ea_al;
      end
      if (commit_valid) begin
        pc <= npc_q;
        order <= order + 64'd1;
        halt_o <= halt_o | (insn_q == HALT_INSN);
      end
    end
  assign commit_valid = !rst && state == COMMIT;
  assign commit_order = order;
  assign commit_insn = insn_q;
  assign commit_pc_rdata = pc;
  assign commit_pc_wdata = npc_q;
  assign commit_rs1_addr = ins[19:15];
  assign commit_rs1_rdata = rs1v;
  assign commit_rs2_addr = ins[24:20];
  assign commit_rs2_rdata = rs2v;
  assign commit_rd_addr = rd_a;
  assign commit_rd_wdata = rd_a == 5'd0 ? 32'd0 : is_ld ? ldata : wd_q;
  assign commit_mem_addr = is_ld || is_st ? {ea_q[31:2], 2'b0} : 32'd0;
  assign commit_mem_rmask = is_ld ? m4 : 4'd0;
  assign commit_mem_wmask = is_st ? m4 : 4'd0;
  assign commit_mem_rdata = is_ld ? old_word : 32'd0;
  assign commit_mem_wdata = is_st ? sdata : 32'd0;
endmodule

// File: tb/tb_rv32i_mc_core.sv
// tb_rv32i_mc_core: directed program with commit/write-beat scoreboards against a line memory model
module tb_rv32i_mc_core;
  localparam logic [31:0] B = 32'h1ECEB000;
  logic clk = 1'b0, rst = 1'b1, bmem_ready = 1'b0, bmem_rvalid = 1'b0;
  logic [31:0] bmem_addr, bmem_raddr = '0;
  logic bmem_read, bmem_write;
  logic [63:0] bmem_wdata, bmem_rdata = '0;
  rv32i_mc_core dut (
    .clk(clk), .rst(rst), .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] insn, pc, npc, wd, maddr;
    logic [4:0] rd;
    logic [3:0] rm, wm;
  } exp_t;
  exp_t cq[$];
  exp_t x;
  logic [95:0] wq[$];
  logic [95:0] w;
  logic [96:0] bq[$];
  logic [255:0] mem [logic [31:0]];
  logic [255:0] ml;
  int tests = 0, fails = 0, nreads = 0, nwrites = 0, ncommit = 0, wbi = 0, n0 = 0, w0 = 0;
  bit inject = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [255:0] rd_line(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction
  function automatic exp_t e(input logic [31:0] insn, pc, npc, input logic [4:0] rd,
                             input logic [31:0] wd, maddr, input logic [3:0] rm, wm);
    exp_t t;
    t.insn = insn; t.pc = pc; t.npc = npc; t.rd = rd; t.wd = wd; t.maddr = maddr; t.rm = rm; t.wm = wm;
    return t;
  endfunction
  always @(negedge clk) begin
    if (bmem_read || bmem_write) chk("rd_wr_excl", {63'b0, bmem_read & bmem_write}, 64'd0);
    if (bmem_read) begin
      nreads++;
      ml = rd_line(bmem_addr);
      for (int k = 0; k < 4; k++) begin
        bq.push_back({1'b1, bmem_addr, ml[64*k +: 64]});
        if (inject && k == 1) begin
          bq.push_back({1'b1, bmem_addr ^ 32'h20, 64'hFFFF_FFFF_FFFF_FFFF});
          inject = 1'b0;
        end
      end
    end
    if (bmem_write) begin
      nwrites++;
      if (wq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wbeat_unexpected: got addr %h data %h required none", bmem_addr, bmem_wdata);
      end else begin
        w = wq.pop_front();
        chk("wbeat_addr", {32'b0, bmem_addr}, {32'b0, w[95:64]});
        chk("wbeat_data", bmem_wdata, w[63:0]);
      end
      ml = rd_line(bmem_addr);
      ml[64*wbi +: 64] = bmem_wdata;
      mem[bmem_addr] = ml;
      wbi = (wbi + 1) % 4;
    end
    if (dut.commit_valid) begin
      if (cq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL commit_unexpected: got pc %h insn %h required none", dut.commit_pc_rdata, dut.commit_insn);
      end else begin
        x = cq.pop_front();
        chk("order", dut.commit_order, 64'(ncommit));
        chk("insn", {32'b0, dut.commit_insn}, {32'b0, x.insn});
        chk("pc_rdata", {32'b0, dut.commit_pc_rdata}, {32'b0, x.pc});
        chk("pc_wdata", {32'b0, dut.commit_pc_wdata}, {32'b0, x.npc});
        chk("rd_addr", {59'b0, dut.commit_rd_addr}, {59'b0, x.rd});
        chk("rd_wdata", {32'b0, dut.commit_rd_wdata}, {32'b0, x.wd});
        chk("mem_addr", {32'b0, dut.commit_mem_addr}, {32'b0, x.maddr});
        chk("mem_rmask", {60'b0, dut.commit_mem_rmask}, {60'b0, x.rm});
        chk("mem_wmask", {60'b0, dut.commit_mem_wmask}, {60'b0, x.wm});
      end
      ncommit++;
    end
  end
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bq.size() > 0) {bmem_rvalid, bmem_raddr, bmem_rdata} = bq.pop_front();
      else bmem_rvalid = 1'b0;
    end
  end
  initial begin
    mem[B] = {32'h1081C303, 32'h10818283, 32'h1041A223, 32'hEEF20213,
              32'hDEADC237, 32'h1ECEB1B7, 32'h00108133, 32'h00500093};
    mem[B + 32'h20] = {32'h0, 32'h0, 32'hFE000CE3, 32'h0, 32'hF0002013, 32'h0, 32'h0100046F, 32'h1041A383};
    mem[B + 32'h100] = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
                        32'h33333333, 32'h00000080, 32'h22222222, 32'h11111111};
    bmem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read", {63'b0, bmem_read}, 64'd0);
    chk("rst_write", {63'b0, bmem_write}, 64'd0);
    chk("rst_addr", {32'b0, bmem_addr}, 64'd0);
    chk("rst_wdata", bmem_wdata, 64'd0);
    chk("rst_commit", {63'b0, dut.commit_valid}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("first_read", {63'b0, bmem_read}, 64'd1);
    chk("first_addr", {32'b0, bmem_addr}, {32'b0, B});
    @(negedge clk);
    chk("read_one_cycle", {63'b0, bmem_read}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n0 = nreads;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("no_req_not_ready", 64'(nreads), 64'(n0));
    cq.push_back(e(32'h00500093, B,         B + 32'h04, 5'd1, 32'd5,        32'd0,        4'h0, 4'h0));
    cq.push_back(e(32'h00108133, B + 32'h04, B + 32'h08, 5'd2, 32'd10,       32'd0,        4'h0, 4'h0));
    cq.push_back(e(32'h1ECEB1B7, B + 32'h08, B + 32'h0C, 5'd3, B,            32'd0,        4'h0, 4'h0));
    cq.push_back(e(32'hDEADC237, B + 32'h0C, B + 32'h10, 5'd4, 32'hDEADC000, 32'd0,        4'h0, 4'h0));
    cq.push_back(e(32'hEEF20213, B + 32'h10, B + 32'h14, 5'd4, 32'hDEADBEEF, 32'd0,        4'h0, 4'h0));
    cq.push_back(e(32'h1041A223, B + 32'h14, B + 32'h18, 5'd0, 32'd0,        B + 32'h104, 4'h0, 4'hF));
    cq.push_back(e(32'h10818283, B + 32'h18, B + 32'h1C, 5'd5, 32'hFFFFFF80, B + 32'h108, 4'h1, 4'h0));
    cq.push_back(e(32'h1081C303, B + 32'h1C, B + 32'h20, 5'd6, 32'h00000080, B + 32'h108, 4'h1, 4'h0));
    cq.push_back(e(32'h1041A383, B + 32'h20, B + 32'h24, 5'd7, 32'hDEADBEEF, B + 32'h104, 4'hF, 4'h0));
    cq.push_back(e(32'h0100046F, B + 32'h24, B + 32'h34, 5'd8, B + 32'h28,   32'd0,        4'h0, 4'h0));
    cq.push_back(e(32'hFE000CE3, B + 32'h34, B + 32'h2C, 5'd0, 32'd0,        32'd0,        4'h0, 4'h0));
    cq.push_back(e(32'hF0002013, B + 32'h2C, B + 32'h30, 5'd0, 32'd0,        32'd0,        4'h0, 4'h0));
    wq.push_back({B + 32'h100, 64'hDEADBEEF_11111111});
    wq.push_back({B + 32'h100, 64'h33333333_00000080});
    wq.push_back({B + 32'h100, 64'h55555555_44444444});
    wq.push_back({B + 32'h100, 64'h77777777_66666666});
    @(posedge clk);
    #1;
    inject = 1'b1;
    bmem_ready = 1'b1;
    for (int i = 0; i < 4000 && !dut.halt_o; i++) @(posedge clk);
    @(negedge clk);
    chk("halt", {63'b0, dut.halt_o}, 64'd1);
    n0 = nreads;
    w0 = nwrites;
    repeat (20) @(negedge clk);
    chk("idle_reads", 64'(nreads), 64'(n0));
    chk("idle_writes", 64'(nwrites), 64'(w0));
    chk("commit_count", 64'(ncommit), 64'd12);
    chk("wbeats_left", 64'(wq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
